// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared FSM state and instruction-queue entry types for fetch.
// Rev 1.0
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_INS_W  = 16;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DROP   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INS_W-1:0]  ins;
    logic [FETCH_ADDR_W-1:0] pc_next;
  } fetch_q_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : synchronous circular FIFO with flush, push, pop and count.
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_q_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pipe : PC, single-outstanding imem request FSM and instruction queue.
// Optional build macro: FETCH_PERF_EN (perf_fetch / perf_wait counters). Rev 1.0
// ---------------------------------------------------------------------------
module fetch_pipe
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INS_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(2),
  parameter int                IQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_stall,
  input  logic              imem_done,
  input  logic [INS_W-1:0]  imem_data,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] pc_next,
  output logic              dump
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_wait
`endif
);

  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

  typedef struct packed {
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] pc_next;
  } q_entry_t;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              pending;
  logic              dumped;
  logic              accept;
  logic              push;
  logic              pop;
  logic              flush;
  logic [CNT_W-1:0]  count;
  q_entry_t          head;
  q_entry_t          push_entry;

  // A request is only issued when a queue slot is free, so every push fits.
  assign imem_rd    = !rst && (state == ST_REQ) && (count < CNT_W'(IQ_DEPTH));
  assign imem_addr  = pc;
  assign accept     = imem_rd && !imem_stall;
  assign ins_valid  = (count != '0);
  assign pop        = ins_valid && ins_ready && !flush;
  assign ins        = head.ins;
  assign pc_next    = head.pc_next;
  assign dump       = (state == ST_HALTED) && !pending && !dumped;
  assign push_entry = '{ins: imem_data, pc_next: pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_REQ;
      pc      <= RESET_PC;
      pending <= 1'b0;
      dumped  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pending <= accept ? 1'b1 : (imem_done ? 1'b0 : pending);
      if (dump) dumped <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_REQ: begin
        if (halt) begin
          state_nxt = ST_HALTED;
        end else if (redirect_valid) begin
          flush  = 1'b1;
          pc_nxt = redirect_pc;
          if (accept) state_nxt = ST_DROP;
        end else if (accept) begin
          pc_nxt    = pc + PC_INC;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (halt) begin
          state_nxt = ST_HALTED;
        end else if (redirect_valid) begin
          // A response arriving with the redirect is simply discarded here.
          flush     = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = imem_done ? ST_REQ : ST_DROP;
        end else if (imem_done) begin
          push      = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_DROP: begin
        if (halt) begin
          state_nxt = ST_HALTED;
        end else begin
          if (redirect_valid) pc_nxt = redirect_pc;
          if (imem_done)      state_nxt = ST_REQ;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_REQ;
    endcase
  end

  fetch_queue #(
    .DEPTH   (IQ_DEPTH),
    .entry_t (q_entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head),
    .count     (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_wait  <= '0;
    end else begin
      if (push && (perf_fetch != '1)) perf_fetch <= perf_fetch + 1'b1;
      if (((state == ST_WAIT) || (state == ST_DROP) || (imem_stall && imem_rd))
          && (perf_wait != '1))
        perf_wait <= perf_wait + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_pipe : random stimulus against a queue-based reference model,
// with a second instance reset to 0xFFFE to exercise PC wrap. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_pipe;

  localparam int          IQ_DEPTH = 2;
  localparam logic [15:0] INC      = 16'd2;
  localparam logic [15:0] WRAP_PC  = 16'hFFFE;
  localparam int          N_CYC    = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt, redirect_valid, imem_stall, imem_done, ins_ready;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_rd, ins_valid, dump;
  logic [15:0] imem_addr, ins, pc_next;
  logic        w_imem_rd, w_ins_valid, w_dump;
  logic [15:0] w_imem_addr, w_ins, w_pc_next;

  fetch_pipe #(.IQ_DEPTH(IQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_stall(imem_stall),
    .imem_done(imem_done), .imem_data(imem_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .pc_next(pc_next), .dump(dump)
  );

  fetch_pipe #(.IQ_DEPTH(IQ_DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_rd(w_imem_rd), .imem_addr(w_imem_addr), .imem_stall(imem_stall),
    .imem_done(imem_done), .imem_data(imem_data),
    .ins_valid(w_ins_valid), .ins_ready(ins_ready), .ins(w_ins),
    .pc_next(w_pc_next), .dump(w_dump)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: queue of fetched words plus a few behavioural flags.
  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pcn0;
    logic [15:0] pcn1;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_pc0, m_pc1, mem_addr0, mem_addr1;
  bit          halted, discard, dumped, busy, stray;
  int          lat;

  function automatic bit exp_rd();
    return !rst && !halted && !busy && (mq.size() < IQ_DEPTH);
  endfunction

  function automatic bit exp_dump();
    return halted && !busy && !dumped;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc0   = 16'h0000;
    m_pc1   = WRAP_PC;
    halted  = 0;
    discard = 0;
    dumped  = 0;
  endtask

  task automatic step();
    bit          acc, pop, done, dmp;
    logic [15:0] old0, old1;
    done = busy && (lat == 0);
    acc  = exp_rd() && !imem_stall;
    dmp  = exp_dump();
    old0 = m_pc0;
    old1 = m_pc1;
    if (rst) begin
      stray = busy && !done;
      busy  = 0;
      model_reset();
      return;
    end
    stray = 0;
    pop   = (mq.size() > 0) && ins_ready;
    if (halted) begin
      if (pop) void'(mq.pop_front());
    end else if (halt) begin
      halted = 1;
      if (pop) void'(mq.pop_front());
    end else if (discard) begin
      if (redirect_valid) begin m_pc0 = redirect_pc; m_pc1 = redirect_pc; end
      if (pop) void'(mq.pop_front());
      if (done) discard = 0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc0 = redirect_pc;
      m_pc1 = redirect_pc;
      if (acc || (busy && !done)) discard = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (done) mq.push_back('{ins: imem_data, pcn0: mem_addr0 + INC, pcn1: mem_addr1 + INC});
      if (acc) begin m_pc0 = m_pc0 + INC; m_pc1 = m_pc1 + INC; end
    end
    if (dmp) dumped = 1;
    if (done) busy = 0;
    else if (busy) lat--;
    if (acc) begin
      busy      = 1;
      lat       = $urandom_range(0, 3);
      mem_addr0 = old0;
      mem_addr1 = old1;
    end
  endtask

  initial begin
    bit ready_lo;
    rst = 1; halt = 0; redirect_valid = 0; redirect_pc = '0;
    imem_stall = 0; imem_done = 0; imem_data = '0; ins_ready = 1;
    busy = 0; stray = 0; lat = 0; mem_addr0 = '0; mem_addr1 = '0;
    model_reset();
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      ready_lo       = ((cyc / 64) % 3) == 2;
      rst            = (cyc < 2) || ($urandom_range(0, 149) == 0);
      halt           = ($urandom_range(0, 399) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 16'($urandom) & 16'hFFFE;
      imem_stall     = ($urandom_range(0, 3) == 0);
      ins_ready      = ready_lo ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      imem_done      = (busy && (lat == 0)) || (stray && !rst);
      imem_data      = 16'($urandom);
      #1;
      check("imem_rd",   imem_rd,   exp_rd());
      check("imem_addr", imem_addr, m_pc0);
      check("ins_valid", ins_valid, mq.size() > 0);
      check("dump",      dump,      exp_dump());
      check("wrap_rd",   w_imem_rd, exp_rd());
      check("wrap_addr", w_imem_addr, m_pc1);
      if (mq.size() > 0) begin
        check("ins",       ins,       mq[0].ins);
        check("pc_next",   pc_next,   mq[0].pcn0);
        check("wrap_pcn",  w_pc_next, mq[0].pcn1);
      end
      @(posedge clk);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_pipe.md
# fetch_pipe

Parametrised instruction-fetch stage with a PC register, a handshaked instruction-memory port and a small instruction queue. It sits between the instruction memory and decode. It replaces the single-cycle fetch with a version that:
- tolerates variable memory latency,
- accepts branch/jump redirects from execute with flush,
- decouples decode back-pressure through a parametrised FIFO.

## Interface
- `ADDR_W`, 16, PC and memory address width
- `INS_W`, 16, instruction width
- `RESET_PC`, 0, PC value loaded by reset
- `PC_INC`, 2, PC increment per sequential fetch
- `IQ_DEPTH`, 2, instruction queue entries (power of two, ≥2)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `halt` in 1: stop fetching (HALT retired); sticky until reset
- `redirect_valid` in 1: taken branch/jump; flush and load new PC
- `redirect_pc` in ADDR_W: redirect target
- `imem_rd` out 1: memory read request
- `imem_addr` out ADDR_W: request address (= PC)
- `imem_stall` in 1: memory cannot accept request this cycle
- `imem_done` in 1: read data valid this cycle
- `imem_data` in INS_W: read data
- `ins_valid` out 1: queue head valid
- `ins_ready` in 1: decode consumes head
- `ins` out INS_W: head instruction
- `pc_next` out ADDR_W: head's PC + PC_INC
- `dump` out 1: one-cycle pulse when halted and idle (memory createdump)

## Operation
- FSM states:
  - **REQ:** `imem_rd`=1 iff `count + 0 < IQ_DEPTH` (slot reserved).
  - **WAIT:** one request outstanding.
  - **DROP:** outstanding response to be discarded.
  - **HALTED:** terminal.
- REQ→WAIT on accept (`imem_rd && !imem_stall`); PC ← PC+PC_INC (wrap modulo 2^ADDR_W).
- WAIT→REQ on `imem_done`; `{imem_data, addr+PC_INC}` pushed into queue.
- Only one outstanding request. Queue push is guaranteed to have space (slot reserved at issue).
- Redirect in REQ or WAIT:
  - Queue flushed (count←0); PC ← `redirect_pc`.
  - If a request is outstanding (WAIT, or REQ accepted same cycle): → DROP.
  - Otherwise stays in REQ.
  - Redirect wins over push and pop in the same cycle.
- DROP: `imem_done` discarded; → REQ. Redirect in DROP updates PC only.
- `halt` from REQ/WAIT/DROP: → HALTED. `imem_rd` forced 0. PC frozen.
- HALTED: any outstanding response is discarded. Queue keeps draining to decode. `redirect_valid` ignored.
- `dump` pulses exactly once: first cycle in HALTED with no outstanding request.
- Queue: circular buffer; pop when `ins_valid && ins_ready`. Push and pop in the same cycle keep count.

## Timing
- Reset values:
  - PC=`RESET_PC`, state REQ, count 0
  - `ins_valid`=0, `imem_rd`=0, `dump`=0, DROP/outstanding flags clear
- `imem_rd` asserts the first cycle after `rst` deasserts.
- `imem_addr` is driven from the PC register and is stable while `imem_stall`=1.
- Latency: a response in cycle N appears as `ins_valid` in N+1.
- Throughput: at most one instruction per 2 cycles (request cycle + done cycle ≥1 later).
- `rst` mid-operation: everything returns to reset values next edge; a pending `imem_done` afterwards is ignored (state REQ, nothing outstanding).
- Simultaneous `halt` and `redirect_valid`: halt wins; PC not updated.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetch` (32b, pushed instructions) and `perf_wait` (32b, cycles in WAIT/DROP or `imem_stall` with `imem_rd`). Both reset to 0, saturating.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package `fetch_pkg`: FSM state enum (REQ, WAIT, DROP, HALTED) and `fetch_q_entry_t {ins, pc_next}`.
- One sub-module: `fetch_queue`, a parametrised synchronous FIFO with flush, push, pop, count, head.
- PC, FSM and handshake stay in `fetch_pipe`.

## Test plan
- **Reset/sequential:** `rst` 2 cycles, memory 1-cycle done, `ins_ready`=1. Requests at 0x0000, 0x0002, 0x0004; `pc_next` 0x0002, 0x0004, 0x0006; `ins_valid` every other cycle.
- **Stall:** `imem_stall`=1 for 3 cycles at PC 0x0004. `imem_addr` holds 0x0004, PC unchanged, no push.
- **Back-pressure:** `ins_ready`=0 with IQ_DEPTH=2. Exactly 2 entries fill, then `imem_rd`=0. Releasing `ins_ready` pops in order.
- **Redirect mid-flight:** redirect to 0x0100 while WAIT. Queue empty next cycle; the stale response is dropped; next request at 0x0100.
- **Halt:** `halt` while WAIT. `imem_rd` stays 0, `dump` pulses once after the response cycle, and a later redirect to 0x0200 is ignored.
- **Wrap:** `RESET_PC`=0xFFFE. Second request at 0x0000; first `pc_next`=0x0000.
